// File: rtl/uart_hex_pkg.sv
// ============================================================================
// uart_hex_pkg : shared FSM encoding, ASCII constants and nibble formatter
// Revision 1.0 | Macro UART_HEX_CRLF_EN selects "\r\n" (else space) separator
// ============================================================================
`default_nettype none

package uart_hex_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

`ifdef UART_HEX_CRLF_EN
  localparam int NCHAR = 4;
`else
  localparam int NCHAR = 3;
`endif

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble, input logic upper);
    logic [7:0] n8;
    n8 = {4'h0, nibble};
    if (nibble < 4'd10)
      return ASCII_0 + n8;
    else if (upper)
      return ASCII_UA + n8 - 8'd10;
    else
      return ASCII_LA + n8 - 8'd10;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hex_byte_fifo.sv
// ============================================================================
// hex_byte_fifo : synchronous FIFO with push/pop/full/empty/count
// Revision 1.0
// ============================================================================
`default_nettype none

module hex_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign o_full  = (count_q == FULL_CNT);
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  // A push into a full FIFO lands only when a pop frees the slot in the same cycle
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_hex_tx_formatter.sv
// ============================================================================
// uart_hex_tx_formatter : byte FIFO -> two ASCII hex chars + separator to UART_TX
// Revision 1.0 | Macro UART_HEX_CRLF_EN: separator "\r\n" when defined, else " "
// ============================================================================
`default_nettype none

module uart_hex_tx_formatter
  import uart_hex_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit UPPERCASE  = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx_dr,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_busy,
  output logic       o_idle
);

  localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] LAST_CIDX = 2'(NCHAR - 1);

  state_e       state_q, state_d;
  logic [1:0]   cidx_q, cidx_d;
  logic [7:0]   cur_byte_q, cur_byte_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic         tx_dr;
  logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]   fifo_data;
  logic [CW-1:0] fifo_count;

  function automatic logic [7:0] char_at(input logic [7:0] b, input logic [1:0] idx);
    case (idx)
      2'd0:    char_at = nibble_to_ascii(b[7:4], UPPERCASE);
      2'd1:    char_at = nibble_to_ascii(b[3:0], UPPERCASE);
`ifdef UART_HEX_CRLF_EN
      2'd2:    char_at = ASCII_CR;
      default: char_at = ASCII_LF;
`else
      default: char_at = ASCII_SP;
`endif
    endcase
  endfunction

  hex_byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (fifo_push),
    .i_data  (i_data),
    .i_pop   (fifo_pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // Ready also in the IDLE pop cycle so a full FIFO can take a byte while one leaves
  assign o_ready   = ~fifo_full | fifo_pop;
  assign fifo_push = i_valid & o_ready;
  assign o_tx_dr   = tx_dr & ~i_reset;
  assign o_tx_data = tx_data_q;
  assign o_idle    = (fifo_count == '0) && (state_q == ST_IDLE);

  always_comb begin
    state_d    = state_q;
    cidx_d     = cidx_q;
    cur_byte_d = cur_byte_q;
    tx_data_d  = tx_data_q;
    fifo_pop   = 1'b0;
    tx_dr      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          cur_byte_d = fifo_data;
          cidx_d     = 2'd0;
          tx_data_d  = char_at(fifo_data, 2'd0);
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!i_tx_busy) begin
          tx_dr   = 1'b1;
          state_d = ST_HOLD;
        end
      end
      // Covers the cycle before UART_TX reflects the request on its busy flag
      ST_HOLD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!i_tx_busy) begin
          if (cidx_q == LAST_CIDX) begin
            state_d = ST_IDLE;
          end else begin
            cidx_d    = cidx_q + 2'd1;
            tx_data_d = char_at(cur_byte_q, cidx_q + 2'd1);
            state_d   = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      cidx_q     <= 2'd0;
      cur_byte_q <= 8'h00;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cidx_q     <= cidx_d;
      cur_byte_q <= cur_byte_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_hex_tx_formatter.sv
// ============================================================================
// tb_uart_hex_tx_formatter : self-checking bench with UART_TX busy model
// Revision 1.0 | Honours UART_HEX_CRLF_EN for the expected separator
// ============================================================================
`default_nettype none

module tb_uart_hex_tx_formatter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: uppercase digits; instance 1: lowercase digits
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic       rdy0, rdy1, dr0, dr1, idle0, idle1;
  logic [7:0] txd0, txd1;
  logic       busy0, busy1;
  logic       force0 = 1'b0;
  int         bcnt0 = 0, bcnt1 = 0;
  logic       dr0_prev = 1'b0, dr1_prev = 1'b0;
  logic [7:0] cap0[$];
  logic [7:0] cap1[$];
  logic [7:0] exp_q[$];
  int         viol = 0;
  int         checks = 0, errors = 0;

  assign busy0 = force0 | (bcnt0 != 0);
  assign busy1 = (bcnt1 != 0);

  uart_hex_tx_formatter #(.FIFO_DEPTH(4), .UPPERCASE(1'b1)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(v0), .i_data(d0), .o_ready(rdy0),
    .o_tx_dr(dr0), .o_tx_data(txd0), .i_tx_busy(busy0), .o_idle(idle0)
  );

  uart_hex_tx_formatter #(.FIFO_DEPTH(4), .UPPERCASE(1'b0)) dut_lc (
    .i_clk(clk), .i_reset(rst), .i_valid(v1), .i_data(d1), .o_ready(rdy1),
    .o_tx_dr(dr1), .o_tx_data(txd1), .i_tx_busy(busy1), .o_idle(idle1)
  );

  // UART_TX model: busy for 10 cycles starting the cycle after the dr pulse
  always @(posedge clk) begin
    if (dr0 === 1'b1) begin
      cap0.push_back(txd0);
      bcnt0 <= 10;
      if (busy0 === 1'b1 || dr0_prev === 1'b1) viol++;
    end else if (bcnt0 != 0) bcnt0 <= bcnt0 - 1;
    dr0_prev <= dr0;
    if (dr1 === 1'b1) begin
      cap1.push_back(txd1);
      bcnt1 <= 10;
      if (busy1 === 1'b1 || dr1_prev === 1'b1) viol++;
    end else if (bcnt1 != 0) bcnt1 <= bcnt1 - 1;
    dr1_prev <= dr1;
  end

  function automatic logic [7:0] ref_digit(input int n, input bit up);
    if (n < 10) return 8'(48 + n);
    return 8'((up ? 65 : 97) + n - 10);
  endfunction

  function automatic void ref_push(input logic [7:0] b, input bit up);
    exp_q.push_back(ref_digit(int'(b) / 16, up));
    exp_q.push_back(ref_digit(int'(b) % 16, up));
`ifdef UART_HEX_CRLF_EN
    exp_q.push_back(8'd13);
    exp_q.push_back(8'd10);
`else
    exp_q.push_back(8'd32);
`endif
  endfunction

  task automatic wait_drain(input int which, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      if (which == 0) ok = idle0 && (bcnt0 == 0) && !force0;
      else            ok = idle1 && (bcnt1 == 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rdy0 !== 1'b1) begin $display("FAIL reset_ready: got %b want 1", rdy0); errors++; end
    checks++; if (dr0 !== 1'b0) begin $display("FAIL reset_dr: got %b want 0", dr0); errors++; end
    checks++; if (txd0 !== 8'h00) begin $display("FAIL reset_data: got %h want 00", txd0); errors++; end
    checks++; if (idle0 !== 1'b1) begin $display("FAIL reset_idle: got %b want 1", idle0); errors++; end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (idle1 !== 1'b1 || rdy1 !== 1'b1) begin
      $display("FAIL reset_lc: got idle %b ready %b want 1 1", idle1, rdy1); errors++;
    end
  endtask

  task automatic test_single();
    int lat; bit ok;
    cap0.delete(); exp_q.delete();
    @(negedge clk); v0 = 1'b1; d0 = 8'h4A; ref_push(8'h4A, 1'b1);
    lat = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk); v0 = 1'b0;
      if (dr0 === 1'b1) lat = k;
    end
    checks++; if (lat !== 2) begin $display("FAIL single_latency: got %0d want 2 cycles after push", lat); errors++; end
    wait_drain(0, ok);
    checks++; if (!ok) begin $display("FAIL single_drain: got timeout want idle"); errors++; end
    checks++; if (cap0.size() !== exp_q.size()) begin
      $display("FAIL single_len: got %0d want %0d", cap0.size(), exp_q.size()); errors++;
    end
    for (int i = 0; i < exp_q.size() && i < cap0.size(); i++) begin
      checks++; if (cap0[i] !== exp_q[i]) begin $display("FAIL single_char%0d: got %h want %h", i, cap0[i], exp_q[i]); errors++; end
    end
    checks++; if (idle0 !== 1'b1) begin $display("FAIL single_idle: got %b want 1", idle0); errors++; end
  endtask

  task automatic test_lowercase();
    bit ok;
    cap1.delete(); exp_q.delete();
    @(negedge clk); v1 = 1'b1; d1 = 8'hAF; ref_push(8'hAF, 1'b0);
    @(negedge clk); d1 = 8'h09; ref_push(8'h09, 1'b0);
    @(negedge clk); v1 = 1'b0;
    wait_drain(1, ok);
    checks++; if (!ok) begin $display("FAIL lower_drain: got timeout want idle"); errors++; end
    checks++; if (cap1.size() !== exp_q.size()) begin
      $display("FAIL lower_len: got %0d want %0d", cap1.size(), exp_q.size()); errors++;
    end
    for (int i = 0; i < exp_q.size() && i < cap1.size(); i++) begin
      checks++; if (cap1[i] !== exp_q[i]) begin $display("FAIL lower_char%0d: got %h want %h", i, cap1[i], exp_q[i]); errors++; end
    end
  endtask

  task automatic test_overflow();
    bit ok; logic [7:0] b;
    cap0.delete(); exp_q.delete();
    force0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); b = 8'($urandom); v0 = 1'b1; d0 = b;
      checks++; if (rdy0 !== (i < 5)) begin $display("FAIL ovf_ready%0d: got %b want %b", i, rdy0, (i < 5)); errors++; end
      if (i < 5) ref_push(b, 1'b1);
    end
    @(negedge clk); v0 = 1'b0;
    repeat (3) @(negedge clk);
    force0 = 1'b0;
    wait_drain(0, ok);
    checks++; if (!ok) begin $display("FAIL ovf_drain: got timeout want idle"); errors++; end
    checks++; if (cap0.size() !== exp_q.size()) begin
      $display("FAIL ovf_len: got %0d want %0d", cap0.size(), exp_q.size()); errors++;
    end
    for (int i = 0; i < exp_q.size() && i < cap0.size(); i++) begin
      checks++; if (cap0[i] !== exp_q[i]) begin $display("FAIL ovf_char%0d: got %h want %h", i, cap0[i], exp_q[i]); errors++; end
    end
  endtask

  task automatic test_full_pop();
    bit ok, got; logic [7:0] b;
    cap0.delete(); exp_q.delete();
    force0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); b = 8'(8'h10 * i + 8'h07); v0 = 1'b1; d0 = b; ref_push(b, 1'b1);
    end
    @(negedge clk); v0 = 1'b0;
    checks++; if (rdy0 !== 1'b0) begin $display("FAIL fullpop_full: got ready %b want 0", rdy0); errors++; end
    force0 = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 500 && !got; k++) begin
      @(negedge clk);
      if (rdy0 === 1'b1) got = 1'b1;
    end
    checks++; if (!got) begin $display("FAIL fullpop_window: got timeout want ready pulse"); errors++; end
    v0 = 1'b1; d0 = 8'hE6; ref_push(8'hE6, 1'b1);
    @(negedge clk); v0 = 1'b0;
    checks++; if (rdy0 !== 1'b0) begin $display("FAIL fullpop_count: got ready %b want 0 (still full)", rdy0); errors++; end
    wait_drain(0, ok);
    checks++; if (cap0.size() !== exp_q.size()) begin
      $display("FAIL fullpop_len: got %0d want %0d", cap0.size(), exp_q.size()); errors++;
    end
    for (int i = 0; i < exp_q.size() && i < cap0.size(); i++) begin
      checks++; if (cap0[i] !== exp_q[i]) begin $display("FAIL fullpop_char%0d: got %h want %h", i, cap0[i], exp_q[i]); errors++; end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, got;
    cap0.delete(); exp_q.delete();
    @(negedge clk); v0 = 1'b1; d0 = 8'h5C;
    @(negedge clk); d0 = 8'h11;
    @(negedge clk); v0 = 1'b0;
    exp_q.push_back(8'h35); exp_q.push_back(8'h43);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (cap0.size() >= 2) got = 1'b1;
    end
    checks++; if (!got) begin $display("FAIL rmid_reach: got timeout want second char"); errors++; end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (dr0 !== 1'b0) begin $display("FAIL rmid_dr_in_reset: got %b want 0", dr0); errors++; end
    @(negedge clk);
    checks++; if (rdy0 !== 1'b1 || dr0 !== 1'b0 || txd0 !== 8'h00 || idle0 !== 1'b1) begin
      $display("FAIL rmid_outputs: got ready %b dr %b data %h idle %b want 1 0 00 1", rdy0, dr0, txd0, idle0); errors++;
    end
    rst = 1'b0;
    wait_drain(0, ok);
    @(negedge clk); v0 = 1'b1; d0 = 8'h00; ref_push(8'h00, 1'b1);
    @(negedge clk); v0 = 1'b0;
    wait_drain(0, ok);
    checks++; if (cap0.size() !== exp_q.size()) begin
      $display("FAIL rmid_len: got %0d want %0d", cap0.size(), exp_q.size()); errors++;
    end
    for (int i = 0; i < exp_q.size() && i < cap0.size(); i++) begin
      checks++; if (cap0[i] !== exp_q[i]) begin $display("FAIL rmid_char%0d: got %h want %h", i, cap0[i], exp_q[i]); errors++; end
    end
  endtask

  task automatic test_random();
    bit ok; int acc; logic [7:0] b;
    cap0.delete(); exp_q.delete();
    acc = 0;
    for (int k = 0; k < 30000 && acc < 200; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 60) begin
        b = 8'($urandom); v0 = 1'b1; d0 = b;
        if (rdy0 === 1'b1) begin ref_push(b, 1'b1); acc++; end
      end else v0 = 1'b0;
    end
    @(negedge clk); v0 = 1'b0;
    checks++; if (acc !== 200) begin $display("FAIL rand_accept: got %0d want 200", acc); errors++; end
    wait_drain(0, ok);
    checks++; if (!ok) begin $display("FAIL rand_drain: got timeout want idle"); errors++; end
    checks++; if (cap0.size() !== exp_q.size()) begin
      $display("FAIL rand_len: got %0d want %0d", cap0.size(), exp_q.size()); errors++;
    end
    for (int i = 0; i < exp_q.size() && i < cap0.size(); i++) begin
      checks++; if (cap0[i] !== exp_q[i]) begin $display("FAIL rand_char%0d: got %h want %h", i, cap0[i], exp_q[i]); errors++; end
    end
    checks++; if (viol !== 0) begin $display("FAIL dr_protocol: got %0d violations want 0", viol); errors++; end
  endtask

  initial begin
    test_reset();
    test_single();
    test_lowercase();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
